// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches RESET_PC..LAST_PC from a combinational imem into a one-entry ready/valid output slot
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] LAST_PC  = 8'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t      state, state_n;
  logic [7:0]  pc, pc_n, instr_pc_n;
  logic [31:0] instr_n;
  logic        valid_n, free;
  assign free      = !instr_valid || instr_ready;
  assign imem_addr = pc;
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 8'h0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
    end
  end
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    if (abort && state != IDLE) begin
      valid_n = 1'b0;
      state_n = IDLE;
    end else if (redirect && state != IDLE) begin
      valid_n = 1'b0;
      pc_n    = redirect_pc;
      state_n = FETCH;
    end else if (start && (state == IDLE || state == DONE)) begin
      pc_n    = RESET_PC;
      state_n = FETCH;
    end else if (state == FETCH && free) begin
      instr_n    = imem_rd;
      instr_pc_n = pc;
      valid_n    = 1'b1;
      pc_n       = pc + 8'd1;
      state_n    = (pc == LAST_PC) ? DRAIN : FETCH;
    end else if (state == DRAIN && free) begin
      valid_n = 1'b0;
      state_n = DONE;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors for fetch_sequencer with a {24'h0,addr} ROM
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, abort, instr_ready, redirect, instr_valid, busy, done;
  logic [7:0]  imem_addr, instr_pc, redirect_pc, e;
  logic [31:0] imem_rd, instr;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  assign imem_rd = {24'h0, imem_addr};
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [7:0] p);
    chk({tag, "_valid"}, instr_valid, v);
    chk({tag, "_pc"}, instr_pc, p);
    chk({tag, "_instr"}, instr, {24'h0, p});
  endtask
  initial begin
    reset = 1; start = 0; abort = 0; instr_ready = 1; redirect = 0; redirect_pc = 0;
    step(); step();
    reset = 0;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 1; step(); start = 0;
    chk("st_busy", busy, 1);
    chk("st_valid", instr_valid, 0);
    chk("st_addr", imem_addr, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("stream", 1, 8'(i));
      chk("stream_busy", busy, 1);
    end
    step();
    chk("drain_done", done, 1);
    chk("drain_valid", instr_valid, 0);
    chk("drain_busy", busy, 0);
    step();
    chk("done_hold", done, 1);
    start = 1; step(); start = 0;
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    step();
    expect_out("restart", 1, 8'h00);
    step(); step();
    expect_out("bp_pre", 1, 8'h02);
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("bp_stall", 1, 8'h02);
      chk("bp_addr", imem_addr, 8'h03);
    end
    instr_ready = 1;
    for (int i = 3; i < 6; i++) begin
      step();
      expect_out("bp_resume", 1, 8'(i));
    end
    step();
    chk("bp_done", done, 1);
    start = 1; step(); start = 0;
    step(); step();
    expect_out("rd_pre", 1, 8'h01);
    redirect = 1; redirect_pc = 8'h10; step(); redirect = 0;
    chk("rd_valid", instr_valid, 0);
    chk("rd_addr", imem_addr, 8'h10);
    chk("rd_busy", busy, 1);
    e = 8'h10;
    forever begin
      step();
      expect_out("rd_seq", 1, e);
      if (e == 8'h05) break;
      e = e + 8'd1;
    end
    step();
    chk("rd_done", done, 1);
    start = 1; step(); start = 0;
    step();
    expect_out("ab_pre", 1, 8'h00);
    abort = 1; redirect = 1; redirect_pc = 8'h40; step(); abort = 0; redirect = 0;
    chk("ab_valid", instr_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    step();
    chk("ab_idle_busy", busy, 0);
    start = 1; step(); start = 0;
    chk("ab_restart_addr", imem_addr, 8'h00);
    step();
    expect_out("ab_restart", 1, 8'h00);
    instr_ready = 0;
    step();
    expect_out("mr_stall", 1, 8'h00);
    reset = 1; step(); reset = 0;
    chk("mr_valid", instr_valid, 0);
    chk("mr_instr", instr, 0);
    chk("mr_pc", instr_pc, 0);
    chk("mr_addr", imem_addr, 8'h00);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    redirect = 1; redirect_pc = 8'h33; step(); redirect = 0;
    chk("idle_rd_busy", busy, 0);
    chk("idle_rd_addr", imem_addr, 8'h00);
    chk("idle_rd_valid", instr_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 8'h00: fetch start address loaded on each start.
REQ-002 Parameter LAST_PC, 8'h05: final address fetched before the sequence completes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a fetch sequence at RESET_PC.
REQ-006 abort  input  1  stops fetching; flushes output; returns to IDLE.
REQ-007 imem_addr  output  8  address driven to the combinational instruction memory (A port).
REQ-008 imem_rd  input  32  instruction word returned by memory, same cycle (RD port).
REQ-009 instr  output  32  registered instruction word presented downstream.
REQ-010 instr_pc  output  8  address from which instr was fetched.
REQ-011 instr_valid  output  1  instr/instr_pc hold a valid, unconsumed instruction.
REQ-012 instr_ready  input  1  downstream accepts instr this cycle when instr_valid=1.
REQ-013 redirect  input  1  branch/jump: flush output, continue fetching at redirect_pc.
REQ-014 redirect_pc  input  8  redirect target, sampled when redirect=1.
REQ-015 busy  output  1  high in FETCH and DRAIN states.
REQ-016 done  output  1  high in DONE state (sequence complete, output empty).

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN, DONE; the pc register SHALL be 8 bits and wrap 8'hFF->8'h00.
REQ-018 imem_addr SHALL equal pc combinationally in all states.
REQ-019 Transfer SHALL occur on a cycle where instr_valid=1 and instr_ready=1; the slot is "free" when instr_valid=0 or a transfer occurs.
REQ-020 IDLE: start=1 -> pc<=RESET_PC, next FETCH; no load occurs; instr_valid SHALL be 0.
REQ-021 FETCH, slot free, no redirect/abort: instr<=imem_rd, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-022 FETCH, slot not free (valid=1, ready=0): instr, instr_pc, instr_valid, pc SHALL hold (stall; no instruction lost or duplicated).
REQ-023 FETCH load with pc==LAST_PC: state<=DRAIN after the load; pc<=pc+1 still applies.
REQ-024 DRAIN: no loads; instr_valid<=0 on transfer; next DONE when output empty (valid=0, or transfer this cycle).
REQ-025 DONE: start=1 -> pc<=RESET_PC, next FETCH; otherwise remain DONE.
REQ-026 redirect=1 in FETCH, DRAIN or DONE: instr_valid<=0, pc<=redirect_pc, state<=FETCH; no load that cycle; a concurrent transfer still counts as consumed downstream.
REQ-027 redirect in IDLE SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state: instr_valid<=0, state<=IDLE; abort SHALL take priority over redirect and start.
REQ-029 start while in FETCH or DRAIN SHALL be ignored.
REQ-030 Latency: start sampled at edge N -> first load at edge N+1 -> instr_valid=1 after edge N+1; with instr_ready held 1, one instruction per cycle.
REQ-031 Priority per edge: reset > abort > redirect > start > load/stall.

Reset
REQ-032 reset=1 at an edge SHALL set state=IDLE, pc=RESET_PC, instr=32'h0, instr_pc=8'h0, instr_valid=0, busy=0, done=0, regardless of state or other inputs.
REQ-033 reset mid-sequence SHALL discard any pending instruction; no transfer is signalled after it.

Verification
REQ-034 Streaming: ROM RD={24'h0,A}, ready=1, start pulse -> instr_pc 0,1,2,3,4,5 on consecutive cycles, then DRAIN, done=1 one cycle after last transfer.
REQ-035 Backpressure: ready=0 for 3 cycles while instr_pc=2 -> instr, instr_pc, imem_addr=3 stay constant; after release, sequence continues 3,4,5 with no gap or duplicate.
REQ-036 Redirect: redirect=1, redirect_pc=8'h10 while instr_pc=1 valid -> next cycle instr_valid=0, imem_addr=8'h10; following cycle instr_pc=8'h10; sequence continues 11,12,... to wrap FF->00, stops after LAST_PC.
REQ-037 Abort vs redirect: abort=1 and redirect=1 same cycle in FETCH -> IDLE, instr_valid=0, busy=0; start again -> fetch restarts at RESET_PC.
REQ-038 Reset mid-operation: reset=1 with instr_valid=1, ready=0 in FETCH -> next cycle all outputs at reset values, imem_addr=RESET_PC, no transfer.
REQ-039 Restart from DONE: start in DONE -> busy=1, done=0, instr_pc=RESET_PC after one cycle.
